// File: rtl/divider_seq.sv
// Iterative restoring divider: one quotient bit per cycle, result pulse W+1 cycles after accept.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module divider_seq #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         valid_in,
  output logic         ready,
  output logic [W-1:0] out,
  output logic [W-1:0] rem,
  output logic         div_by_zero,
  output logic         valid_out
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W:0]      prem_reg;
  logic [W-1:0]    quot_reg;
  logic [W-1:0]    divisor_reg;
  logic [CW-1:0]   count_reg;
  logic            zero_reg;
  logic [W-1:0]    out_reg;
  logic [W-1:0]    rem_reg;
  logic            dbz_reg;

  logic            accept;
  logic [W+1:0]    shifted;
  logic [W+1:0]    trial;
  logic [W:0]      prem_next;
  logic [W-1:0]    quot_next;
  logic [W-1:0]    dvd_mag;
  logic [W-1:0]    dvs_mag;
  logic [W-1:0]    q_final;
  logic [W-1:0]    r_final;

  assign accept = valid_in && ready;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_in) state_next = RUN;
      RUN:     if (count_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_reg == IDLE);
    valid_out = (state_reg == DONE);
  end

  // Top bit of the shifted value is always 0, so trial[W+1] is the borrow of the subtraction.
  assign shifted   = {1'b0, prem_reg[W-1:0], quot_reg[W-1]} | {prem_reg[W], {(W+1){1'b0}}};
  assign trial     = shifted - {2'b00, divisor_reg};
  assign prem_next = trial[W+1] ? shifted[W:0] : trial[W:0];
  assign quot_next = {quot_reg[W-2:0], ~trial[W+1]};

`ifdef DIVIDER_SIGNED_EN
  logic sign_q_reg;
  logic sign_r_reg;

  assign dvd_mag = in0[W-1] ? -in0 : in0;
  assign dvs_mag = in1[W-1] ? -in1 : in1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
    end else if (accept) begin
      sign_q_reg <= in0[W-1] ^ in1[W-1];
      sign_r_reg <= in0[W-1];
    end
  end

  // A zero divisor keeps the raw all-ones quotient regardless of sign.
  assign q_final = (sign_q_reg && !zero_reg) ? -quot_next : quot_next;
  assign r_final = sign_r_reg ? -prem_next[W-1:0] : prem_next[W-1:0];
`else
  assign dvd_mag = in0;
  assign dvs_mag = in1;
  assign q_final = quot_next;
  assign r_final = prem_next[W-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      prem_reg    <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      zero_reg    <= 1'b0;
      out_reg     <= '0;
      rem_reg     <= '0;
      dbz_reg     <= 1'b0;
    end else if (accept) begin
      quot_reg    <= dvd_mag;
      divisor_reg <= dvs_mag;
      prem_reg    <= '0;
      count_reg   <= CW'(W - 1);
      zero_reg    <= (in1 == '0);
    end else if (state_reg == RUN) begin
      prem_reg  <= prem_next;
      quot_reg  <= quot_next;
      count_reg <= count_reg - CW'(1);
      if (count_reg == '0) begin
        out_reg <= q_final;
        rem_reg <= r_final;
        dbz_reg <= zero_reg;
      end
    end
  end

  assign out         = out_reg;
  assign rem         = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and random checks of divider_seq: latency window, busy ignore, reset abort, throughput.
module tb_divider_seq;

  logic        clock;
  logic        reset;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        valid_in;
  logic        ready;
  logic [15:0] out;
  logic [15:0] rem;
  logic        div_by_zero;
  logic        valid_out;

  int n_checks = 0;
  int n_fail   = 0;
  int vo_total = 0;

  divider_seq #(.W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in0         (in0),
    .in1         (in1),
    .valid_in    (valid_in),
    .ready       (ready),
    .out         (out),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .valid_out   (valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valid_out === 1'b1) vo_total++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (n_checks=%0d)", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an operation in the current cycle c and watches cycles c..c+17; returns in cycle c+18.
  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eq, input logic [15:0] er, input logic ez,
                    input string tag, input int busy_k,
                    output logic [15:0] q_obs, output logic [15:0] r_obs);
    int rbad = 0;
    int vbad = 0;
    logic z_obs = 1'b0;
    q_obs = '0;
    r_obs = '0;
    in0 = a;
    in1 = b;
    valid_in = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == busy_k) begin
        in0 = 16'd9;
        in1 = 16'd3;
        valid_in = 1'b1;
      end else if (k > 0) begin
        valid_in = 1'b0;
      end
      @(negedge clock);
      if (ready !== (k == 0)) rbad++;
      if (valid_out !== (k == 17)) vbad++;
      if (k == 17) begin
        q_obs = out;
        r_obs = rem;
        z_obs = div_by_zero;
      end
      @(posedge clock);
      #1;
    end
    valid_in = 1'b0;
    check({tag, "_ready"}, rbad, 0);
    check({tag, "_vout"}, vbad, 0);
    check({tag, "_q"}, q_obs, eq);
    check({tag, "_r"}, r_obs, er);
    check({tag, "_dbz"}, z_obs, ez);
    $display("op %s: %h / %h -> q=%h r=%h z=%b", tag, a, b, q_obs, r_obs, z_obs);
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (valid_out === 1'b1) cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [15:0] q, r, a, b, eq, er;
    logic [31:0] prod;
    int cnt, v0, sa, sb;

    reset = 1'b1;
    valid_in = 1'b0;
    in0 = '0;
    in1 = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", ready, 1);
    check("rst_vout", valid_out, 0);
    check("rst_out", out, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    $display("reset: ready=%b out=%h rem=%h", ready, out, rem);
    @(posedge clock);
    #1;

    op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "basic", -1, q, r);
    op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, "divzero", -1, q, r);

    v0 = vo_total;
    op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, "busy", 5, q, r);
    watch(20, cnt);
    check("busy_extra_vout", cnt, 0);
    check("busy_total_vout", vo_total - v0, 1);
    $display("busy: extra pulses=%0d", cnt);

    // Abort mid-operation: accept at c, reset during c+8, check at c+9.
    in0 = 16'd1000;
    in1 = 16'd10;
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    repeat (7) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready", ready, 1);
    check("abort_out", out, 0);
    check("abort_rem", rem, 0);
    check("abort_vout", valid_out, 0);
    @(posedge clock);
    #1;
    watch(21, cnt);
    check("abort_no_vout", cnt, 0);
    $display("abort: ready=%b pulses=%0d", ready, cnt);

    // Reset wins over a simultaneous valid_in.
    reset = 1'b1;
    valid_in = 1'b1;
    in0 = 16'd50;
    in1 = 16'd5;
    @(posedge clock);
    #1;
    reset = 1'b0;
    valid_in = 1'b0;
    @(negedge clock);
    check("rst_vs_valid_ready", ready, 1);
    $display("reset+valid: ready=%b", ready);
    @(posedge clock);
    #1;

`ifdef DIVIDER_SIGNED_EN
    op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, "s_neg7_2", -1, q, r);
    op(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, "s_minneg", -1, q, r);
    op(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, "s_divzero", -1, q, r);
    op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, "s_7_neg2", -1, q, r);
`else
    op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, "u_max_max", -1, q, r);
    op(16'd3, 16'd7, 16'd0, 16'd3, 1'b0, "u_small", -1, q, r);
    op(16'hFFF9, 16'd2, 16'h7FFC, 16'd1, 1'b0, "u_big_2", -1, q, r);
`endif

    v0 = vo_total;
    for (int i = 0; i < 50; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      eq = 16'(sa / sb);
      er = 16'(sa % sb);
`else
      eq = a / b;
      er = a % b;
`endif
      op(a, b, eq, er, 1'b0, "rand", -1, q, r);
      prod = 32'(q) * 32'(b) + 32'(r);
      check("rand_invariant", prod[15:0], a);
`ifndef DIVIDER_SIGNED_EN
      check("rand_rem_lt", (r < b), 1);
`endif
    end
    @(negedge clock);
    check("rand_final_ready", ready, 1);
    check("rand_pulses", vo_total - v0, 50);
    $display("random: pulses=%0d", vo_total - v0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
